// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory handshake signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_resp_data;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic              lsu_wen;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU,
// one outstanding transaction at a time (IDLE -> REQ -> WAIT -> IDLE).
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus,
    output logic           busy,
    output logic           owner
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last_grant;
    logic              r_owner;
    logic              r_busy;
    logic              r_mem_req_valid;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic              r_ifu_resp_valid;
    logic              r_lsu_resp_valid;
    logic [DATA_W-1:0] r_ifu_resp_data;
    logic [DATA_W-1:0] r_lsu_resp_data;

    logic              w_grant_ifu;
    logic              w_grant_lsu;

    // Grant in IDLE only; on a tie the side that did not win last time goes first.
    always_comb begin
        w_grant_ifu = 1'b0;
        w_grant_lsu = 1'b0;
        if (!rst && (r_state == S_IDLE)) begin
            if (bus.ifu_req_valid && bus.lsu_req_valid) begin
                w_grant_ifu = r_last_grant;
                w_grant_lsu = !r_last_grant;
            end else begin
                w_grant_ifu = bus.ifu_req_valid;
                w_grant_lsu = bus.lsu_req_valid;
            end
        end else begin
            w_grant_ifu = 1'b0;
            w_grant_lsu = 1'b0;
        end
    end

    // Transaction sequencer with registered memory-side and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_last_grant     <= 1'b1;
            r_owner          <= 1'b1;
            r_busy           <= 1'b0;
            r_mem_req_valid  <= 1'b0;
            r_wen            <= 1'b0;
            r_addr           <= {ADDR_W{1'b0}};
            r_wdata          <= {DATA_W{1'b0}};
            r_wmask          <= {MASK_W{1'b0}};
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            r_ifu_resp_data  <= {DATA_W{1'b0}};
            r_lsu_resp_data  <= {DATA_W{1'b0}};
        end else begin
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_lsu) begin
                        r_state         <= S_REQ;
                        r_busy          <= 1'b1;
                        r_mem_req_valid <= 1'b1;
                        r_owner         <= 1'b1;
                        r_last_grant    <= 1'b1;
                        r_wen           <= bus.lsu_wen;
                        r_addr          <= bus.lsu_addr;
                        r_wdata         <= bus.lsu_wdata;
                        r_wmask         <= bus.lsu_wen ? bus.lsu_wmask : {MASK_W{1'b0}};
                    end else if (w_grant_ifu) begin
                        r_state         <= S_REQ;
                        r_busy          <= 1'b1;
                        r_mem_req_valid <= 1'b1;
                        r_owner         <= 1'b0;
                        r_last_grant    <= 1'b0;
                        r_wen           <= 1'b0;
                        r_addr          <= bus.ifu_addr;
                        r_wdata         <= {DATA_W{1'b0}};
                        r_wmask         <= {MASK_W{1'b0}};
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (bus.mem_req_ready) begin
                        r_state         <= S_WAIT;
                        r_mem_req_valid <= 1'b0;
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_WAIT: begin
                    // Stores acknowledge with zero data regardless of the bus contents.
                    if (bus.mem_resp_valid) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (r_owner) begin
                            r_lsu_resp_valid <= 1'b1;
                            r_lsu_resp_data  <= r_wen ? {DATA_W{1'b0}} : bus.mem_resp_data;
                        end else begin
                            r_ifu_resp_valid <= 1'b1;
                            r_ifu_resp_data  <= bus.mem_resp_data;
                        end
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    r_state         <= S_IDLE;
                    r_busy          <= 1'b0;
                    r_mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ifu_req_ready  = w_grant_ifu;
    assign bus.lsu_req_ready  = w_grant_lsu;
    assign bus.ifu_resp_valid = r_ifu_resp_valid;
    assign bus.ifu_resp_data  = r_ifu_resp_data;
    assign bus.lsu_resp_valid = r_lsu_resp_valid;
    assign bus.lsu_resp_data  = r_lsu_resp_data;
    assign bus.mem_req_valid  = r_mem_req_valid;
    assign bus.mem_wen        = r_wen;
    assign bus.mem_addr       = r_addr;
    assign bus.mem_wdata      = r_wdata;
    assign bus.mem_wmask      = r_wmask;
    assign busy               = r_busy;
    assign owner              = r_owner;
endmodule
